// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result/flags. Single-cycle ops complete
// in one edge; rotate-left by n >= 2 is performed one bit per cycle.
module alu_seq #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [2:0]       function_code,
  input  logic [SHW-1:0]   shift_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             sign,
  output logic             carry,
  output logic             zero
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_INC = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_ROL = 3'b110;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ROTATE = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             sign_q, sign_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic [WIDTH:0]   sum_add;
  logic [WIDTH:0]   sum_inc;
  logic [WIDTH-1:0] op_res;
  logic             op_carry;
  logic             op_writes;
  logic             op_multi;
  logic [WIDTH-1:0] acc_rot;

  function automatic logic [WIDTH-1:0] rol1(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], x[WIDTH-1]};
  endfunction

  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign sum_add  = {1'b0, b} + {1'b0, c};
  assign sum_inc  = {1'b0, b} + {{WIDTH{1'b0}}, 1'b1};
  assign acc_rot  = rol1(acc_q);

  // Decode of the single-cycle datapath; op_multi marks rotates handed to the FSM.
  always_comb begin
    op_res    = '0;
    op_carry  = 1'b0;
    op_writes = 1'b1;
    op_multi  = 1'b0;
    case (function_code)
      OP_ADD: begin
        op_res   = sum_add[WIDTH-1:0];
        op_carry = sum_add[WIDTH];
      end
      OP_INC: begin
        op_res   = sum_inc[WIDTH-1:0];
        op_carry = sum_inc[WIDTH];
      end
      OP_AND: op_res = b & c;
      OP_OR:  op_res = b | c;
      OP_XOR: op_res = b ^ c;
      OP_NOT: op_res = ~b;
      OP_ROL: begin
        if (shift_amt > SHW'(1)) begin
          op_multi  = 1'b1;
          op_writes = 1'b0;
        end else if (shift_amt == '0) begin
          op_res = b;
        end else begin
          op_res   = rol1(b);
          op_carry = b[WIDTH-1];
        end
      end
      default: op_writes = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    sign_d      = sign_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op_multi) begin
            acc_d       = rol1(b);
            cnt_d       = shift_amt - SHW'(1);
            out_valid_d = 1'b0;
            state_d     = ST_ROTATE;
          end else begin
            out_valid_d = 1'b1;
            if (op_writes) begin
              result_d = op_res;
              sign_d   = op_res[WIDTH-1];
              carry_d  = op_carry;
              zero_d   = (op_res == '0);
            end
          end
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      ST_ROTATE: begin
        acc_d = acc_rot;
        cnt_d = cnt_q - SHW'(1);
        // Final step: the bit wrapped into position 0 is the carry.
        if (cnt_q == SHW'(1)) begin
          result_d    = acc_rot;
          sign_d      = acc_rot[WIDTH-1];
          carry_d     = acc_rot[0];
          zero_d      = (acc_rot == '0);
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      sign_q      <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      sign_q      <= sign_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign sign      = sign_q;
  assign carry     = carry_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares on every output handshake.
module tb_alu_seq;

  typedef struct packed {
    logic [7:0] r;
    logic       s;
    logic       c;
    logic       z;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] b_in;
  logic [7:0] c_in;
  logic [2:0] fc;
  logic [2:0] sh_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       sign;
  logic       carry;
  logic       zero;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .b(b_in), .c(c_in), .function_code(fc), .shift_amt(sh_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .sign(sign), .carry(carry), .zero(zero)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output actual result=%h s=%0b c=%0b z=%0b required none",
                 result, sign, carry, zero);
      end else begin
        mon_e = exp_q.pop_front();
        if ({result, sign, carry, zero} !== mon_e) begin
          errors++;
          $display("FAIL result_flags actual r=%h s=%0b c=%0b z=%0b required r=%h s=%0b c=%0b z=%0b",
                   result, sign, carry, zero, mon_e.r, mon_e.s, mon_e.c, mon_e.z);
        end else begin
          $display("ok result=%h s=%0b c=%0b z=%0b", result, sign, carry, zero);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic issue(input string nm, input logic [2:0] op, input logic [7:0] bv,
                       input logic [7:0] cv, input logic [2:0] sh, input exp_t ex,
                       input int lat);
    int waited;
    exp_q.push_back(ex);
    in_valid = 1'b1;
    fc       = op;
    b_in     = bv;
    c_in     = cv;
    sh_in    = sh;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      chk({nm, "_accept_timeout"}, in_ready, 1);
      in_valid = 1'b0;
      void'(exp_q.pop_back());
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      chk({nm, "_out_valid"}, out_valid, (k == lat));
      if (k < lat) chk({nm, "_in_ready_busy"}, in_ready, 0);
    end
  endtask

  initial begin
    int waited;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    b_in      = '0;
    c_in      = '0;
    fc        = 3'b111;
    sh_in     = '0;

    #2;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_flags", {sign, carry, zero}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);

    issue("add_ff_01", 3'b000, 8'hFF, 8'h01, 3'd0, '{8'h00, 1'b0, 1'b1, 1'b1}, 1);
    issue("inc_7f",    3'b001, 8'h7F, 8'h00, 3'd0, '{8'h80, 1'b1, 1'b0, 1'b0}, 1);
    issue("inc_ff",    3'b001, 8'hFF, 8'h00, 3'd0, '{8'h00, 1'b0, 1'b1, 1'b1}, 1);
    issue("rol_81_3",  3'b110, 8'h81, 8'h00, 3'd3, '{8'h0C, 1'b0, 1'b0, 1'b0}, 3);
    issue("rol_80_1",  3'b110, 8'h80, 8'h00, 3'd1, '{8'h01, 1'b0, 1'b1, 1'b0}, 1);
    issue("rol_a5_0",  3'b110, 8'hA5, 8'h00, 3'd0, '{8'hA5, 1'b1, 1'b0, 1'b0}, 1);
    issue("rol_c0_2",  3'b110, 8'hC0, 8'h00, 3'd2, '{8'h03, 1'b0, 1'b1, 1'b0}, 2);
    issue("or_50_0a",  3'b011, 8'h50, 8'h0A, 3'd5, '{8'h5A, 1'b0, 1'b0, 1'b0}, 1);
    issue("not_0f",    3'b101, 8'h0F, 8'h33, 3'd0, '{8'hF0, 1'b1, 1'b0, 1'b0}, 1);

    // Backpressure: hold the ADD result for five cycles.
    issue("add_10_20", 3'b000, 8'h10, 8'h20, 3'd0, '{8'h30, 1'b0, 1'b0, 1'b0}, 1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold_result", result, 8'h30);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    issue("xor_f0_ff", 3'b100, 8'hF0, 8'hFF, 3'd0, '{8'h0F, 1'b0, 1'b0, 1'b0}, 1);

    issue("add_ff_01b", 3'b000, 8'hFF, 8'h01, 3'd0, '{8'h00, 1'b0, 1'b1, 1'b1}, 1);
    issue("nop",        3'b111, 8'h12, 8'h34, 3'd0, '{8'h00, 1'b0, 1'b1, 1'b1}, 1);
    issue("and_0f_f3",  3'b010, 8'h0F, 8'hF3, 3'd0, '{8'h03, 1'b0, 1'b0, 1'b0}, 1);

    // Reset in the middle of a long rotate.
    in_valid = 1'b1;
    fc       = 3'b110;
    b_in     = 8'h01;
    sh_in    = 3'd7;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("rol7_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_result", result, 0);
    chk("midrst_flags", {sign, carry, zero}, 0);
    chk("midrst_out_valid", out_valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      chk("postrst_no_valid", out_valid, 0);
      @(posedge clk);
      #1;
    end
    issue("add_01_01", 3'b000, 8'h01, 8'h01, 3'd0, '{8'h02, 1'b0, 1'b0, 1'b0}, 1);

    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
